// File: rtl/sprite_renderer_pkg.sv
// Purpose: shared geometry defaults and the 16-entry sine table for the sprite renderer.
// Contents: default geometry constants, 16x8-bit sine table (one period), shared widths.
// Used by: sprite_renderer (top) and sine_table (lookup sub-module).
package sprite_renderer_pkg;

    // Pixel coordinates arrive as 10 bits; all geometry is evaluated in 11 bits
    // so that position+size can never wrap.
    localparam int unsigned COORD_W = 10;
    localparam int unsigned CALC_W  = 11;

    localparam int unsigned DEF_TOP_X         = 100;
    localparam int unsigned DEF_TOP_Y         = 180;
    localparam int unsigned DEF_BOTTOM_X      = 540;
    localparam int unsigned DEF_BOTTOM_Y      = 400;
    localparam int unsigned DEF_BAR_WIDTH     = 40;
    localparam int unsigned DEF_VISIBLE_WIDTH = 25;
    localparam int unsigned DEF_HEIGHT        = 60;
    localparam int unsigned DEF_PLAYER_X      = 40;
    localparam int unsigned DEF_PLAYER_SIZE   = 16;
    localparam int unsigned DEF_U_SIZE        = 32;
    localparam int unsigned DEF_U_WALL        = 8;

    // One full sine period, offset to 0..255, sampled at 16 points.
    localparam logic [7:0] SINE_TABLE [16] = '{
        8'd128, 8'd176, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd176,
        8'd128, 8'd79,  8'd37,  8'd10,  8'd0,   8'd10,  8'd37,  8'd79
    };

endpackage

// File: rtl/sine_table.sv
// Purpose: combinational 16-entry sine lookup used for wave bar displacement.
// Ports: i_pos (4-bit table index) -> o_value (8-bit sample).
// Latency: zero (pure combinational).
module sine_table
    import sprite_renderer_pkg::*;
(
    input  logic [3:0] i_pos,
    output logic [7:0] o_value
);

    always_comb begin
        o_value = SINE_TABLE[i_pos];
    end

endmodule

// File: rtl/sprite_renderer.sv
// Purpose: per-pixel hit test for player square, U-shaped box and scrolling double-sine bars.
// Ports: clk/rst, pixel position, object positions and scroll in; four registered draw flags out.
// Latency: exactly one clk; outputs cleared asynchronously while rst is high.
module sprite_renderer
    import sprite_renderer_pkg::*;
#(
    parameter int unsigned TOP_X         = DEF_TOP_X,
    parameter int unsigned TOP_Y         = DEF_TOP_Y,
    parameter int unsigned BOTTOM_X      = DEF_BOTTOM_X,
    parameter int unsigned BOTTOM_Y      = DEF_BOTTOM_Y,
    parameter int unsigned BAR_WIDTH     = DEF_BAR_WIDTH,
    parameter int unsigned VISIBLE_WIDTH = DEF_VISIBLE_WIDTH,
    parameter int unsigned HEIGHT        = DEF_HEIGHT,
    parameter int unsigned PLAYER_X      = DEF_PLAYER_X,
    parameter int unsigned PLAYER_SIZE   = DEF_PLAYER_SIZE,
    parameter int unsigned U_SIZE        = DEF_U_SIZE,
    parameter int unsigned U_WALL        = DEF_U_WALL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COORD_W-1:0] player_y,
    input  logic               show_player,
    input  logic [COORD_W-1:0] u_x,
    input  logic [COORD_W-1:0] u_y,
    input  logic [COORD_W-1:0] x_offset,
    output logic               draw_player,
    output logic               draw_u,
    output logic               draw_double_sin,
    output logic               pixel_on
);

    localparam logic [CALC_W-1:0] C_TOP_X     = CALC_W'(TOP_X);
    localparam logic [CALC_W-1:0] C_TOP_Y     = CALC_W'(TOP_Y);
    localparam logic [CALC_W-1:0] C_BOTTOM_X  = CALC_W'(BOTTOM_X);
    localparam logic [CALC_W-1:0] C_BOTTOM_Y  = CALC_W'(BOTTOM_Y);
    localparam logic [CALC_W-1:0] C_BAR_W     = CALC_W'(BAR_WIDTH);
    localparam logic [CALC_W-1:0] C_VIS_W     = CALC_W'(VISIBLE_WIDTH);
    localparam logic [CALC_W-1:0] C_HEIGHT    = CALC_W'(HEIGHT);
    localparam logic [CALC_W-1:0] C_PLAYER_X  = CALC_W'(PLAYER_X);
    localparam logic [CALC_W-1:0] C_PLAYER_SZ = CALC_W'(PLAYER_SIZE);
    localparam logic [CALC_W-1:0] C_U_SIZE    = CALC_W'(U_SIZE);
    localparam logic [CALC_W-1:0] C_U_WALL    = CALC_W'(U_WALL);

    // Zero-extended copies of the 10-bit inputs.
    logic [CALC_W-1:0] w_px, w_py, w_ply, w_ux, w_uy, w_xoff;
    assign w_px   = {1'b0, pix_x};
    assign w_py   = {1'b0, pix_y};
    assign w_ply  = {1'b0, player_y};
    assign w_ux   = {1'b0, u_x};
    assign w_uy   = {1'b0, u_y};
    assign w_xoff = {1'b0, x_offset};

    // ---------------- player ----------------
    logic w_player;
    assign w_player = show_player
                    && (w_px >= C_PLAYER_X) && (w_px < C_PLAYER_X + C_PLAYER_SZ)
                    && (w_py >= w_ply)      && (w_py < w_ply + C_PLAYER_SZ);

    // ---------------- U box ----------------
    // Inside the bounding box, lit on either wall or the floor; the top stays open.
    logic w_u_in_box, w_u_left, w_u_right, w_u_floor, w_u;
    assign w_u_in_box = (w_px >= w_ux) && (w_px < w_ux + C_U_SIZE)
                     && (w_py >= w_uy) && (w_py < w_uy + C_U_SIZE);
    assign w_u_left   = w_px <  w_ux + C_U_WALL;
    assign w_u_right  = w_px >= w_ux + C_U_SIZE - C_U_WALL;
    assign w_u_floor  = w_py >= w_uy + C_U_SIZE - C_U_WALL;
    assign w_u        = w_u_in_box && (w_u_left || w_u_right || w_u_floor);

    // ---------------- double sine wave ----------------
    logic              w_in_region;
    logic [CALC_W-1:0] w_sum, w_bar_num, w_phase;
    logic [3:0]        w_idx;
    logic [7:0]        w_sine;
    logic [CALC_W-1:0] w_disp;
    logic              w_lit, w_top_band, w_bot_band, w_wave;

    assign w_in_region = (w_px >= C_TOP_X) && (w_px < C_BOTTOM_X);
    // Only meaningful inside the region, where pix_x >= TOP_X so no underflow.
    assign w_sum       = w_px - C_TOP_X + w_xoff;
    assign w_bar_num   = w_sum / C_BAR_W;
    assign w_phase     = w_sum % C_BAR_W;
    assign w_idx       = w_bar_num[3:0];

    sine_table u_sine_table (
        .i_pos   (w_idx),
        .o_value (w_sine)
    );

    assign w_disp     = CALC_W'(w_sine >> 3);
    assign w_lit      = w_phase < C_VIS_W;
    assign w_top_band = (w_py >= C_TOP_Y + w_disp) && (w_py < C_TOP_Y + w_disp + C_HEIGHT);
    // Bottom band BOTTOM_Y-HEIGHT-d <= y < BOTTOM_Y-d, rearranged to additions so
    // no intermediate ever goes negative.
    assign w_bot_band = (w_py + C_HEIGHT + w_disp >= C_BOTTOM_Y) && (w_py + w_disp < C_BOTTOM_Y);
    assign w_wave     = w_in_region && w_lit && (w_top_band || w_bot_band);

    // ---------------- output register ----------------
    logic r_player, r_u, r_wave, r_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_player <= 1'b0;
            r_u      <= 1'b0;
            r_wave   <= 1'b0;
            r_on     <= 1'b0;
        end else begin
            r_player <= w_player;
            r_u      <= w_u;
            r_wave   <= w_wave;
            r_on     <= w_player | w_u | w_wave;
        end
    end

    assign draw_player     = r_player;
    assign draw_u          = r_u;
    assign draw_double_sin = r_wave;
    assign pixel_on        = r_on;

endmodule

// File: tb/tb_sprite_renderer.sv
// Purpose: directed self-checking bench for sprite_renderer.
// Ports: none; drives the DUT on falling edges and samples 1 ns after rising edges.
// Expectations are hand-computed from the geometry definitions.
module tb_sprite_renderer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pix_x = '0, pix_y = '0, player_y = '0, u_x = '0, u_y = '0, x_offset = '0;
    logic       show_player = 1'b0;
    logic       draw_player, draw_u, draw_double_sin, pixel_on;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_renderer dut (
        .clk             (clk),
        .rst             (rst),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .player_y        (player_y),
        .show_player     (show_player),
        .u_x             (u_x),
        .u_y             (u_y),
        .x_offset        (x_offset),
        .draw_player     (draw_player),
        .draw_u          (draw_u),
        .draw_double_sin (draw_double_sin),
        .pixel_on        (pixel_on)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one sample on the falling edge, then check all four flags
    // 1 ns after the following rising edge.
    task automatic vec(input string tag,
                       input int px, input int py, input int sp, input int xo,
                       input logic e_pl, input logic e_u, input logic e_w);
        @(negedge clk);
        pix_x       = 10'(px);
        pix_y       = 10'(py);
        show_player = sp[0];
        x_offset    = 10'(xo);
        @(posedge clk);
        #1;
        check({tag, ".player"}, {31'd0, draw_player},     {31'd0, e_pl});
        check({tag, ".u"},      {31'd0, draw_u},          {31'd0, e_u});
        check({tag, ".wave"},   {31'd0, draw_double_sin}, {31'd0, e_w});
        check({tag, ".on"},     {31'd0, pixel_on},        {31'd0, e_pl | e_u | e_w});
    endtask

    initial begin
        player_y = 10'd200;
        u_x      = 10'd300;
        u_y      = 10'd100;
        #1;
        check("rst.player", {31'd0, draw_player},     32'd0);
        check("rst.u",      {31'd0, draw_u},          32'd0);
        check("rst.wave",   {31'd0, draw_double_sin}, 32'd0);
        check("rst.on",     {31'd0, pixel_on},        32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Player square [40,56) x [200,216)
        vec("pl_hit",    45, 210, 1, 0, 1'b1, 1'b0, 1'b0);
        vec("pl_hidden", 45, 210, 0, 0, 1'b0, 1'b0, 1'b0);
        vec("pl_xedge",  56, 210, 1, 0, 1'b0, 1'b0, 1'b0);
        vec("pl_xlow",   40, 200, 1, 0, 1'b1, 1'b0, 1'b0);
        vec("pl_yedge",  45, 216, 1, 0, 1'b0, 1'b0, 1'b0);

        // Latency: new inputs must not show before the next rising edge.
        @(negedge clk);
        pix_x = 10'd45; pix_y = 10'd210; show_player = 1'b1;
        #1;
        check("lat.before", {31'd0, draw_player}, 32'd0);
        @(posedge clk);
        #1;
        check("lat.after",  {31'd0, draw_player}, 32'd1);

        // U box at (300,100), 32x32, walls 8
        vec("u_left",     304, 110, 0, 0, 1'b0, 1'b1, 1'b0);
        vec("u_interior", 315, 110, 0, 0, 1'b0, 1'b0, 1'b0);
        vec("u_floor",    315, 128, 0, 0, 1'b0, 1'b1, 1'b0);
        vec("u_outside",  332, 110, 0, 0, 1'b0, 1'b0, 1'b0);
        vec("u_right",    324, 100, 0, 0, 1'b0, 1'b1, 1'b0);
        vec("u_floorlo",  315, 124, 0, 0, 1'b0, 1'b1, 1'b0);

        // Wave, x_offset 0: idx0 d=16, top band 196..255, bottom 324..383
        vec("w_top",      100, 200, 0, 0, 1'b0, 1'b0, 1'b1);
        vec("w_top_lo",   100, 196, 0, 0, 1'b0, 1'b0, 1'b1);
        vec("w_above",    100, 195, 0, 0, 1'b0, 1'b0, 1'b0);
        vec("w_top_hi",   100, 256, 0, 0, 1'b0, 1'b0, 1'b0);
        vec("w_phase30",  130, 200, 0, 0, 1'b0, 1'b0, 1'b0);
        vec("w_phase24",  124, 200, 0, 0, 1'b0, 1'b0, 1'b1);
        vec("w_phase25",  125, 200, 0, 0, 1'b0, 1'b0, 1'b0);
        vec("w_bottom",   100, 330, 0, 0, 1'b0, 1'b0, 1'b1);
        vec("w_bot_lo",   100, 324, 0, 0, 1'b0, 1'b0, 1'b1);
        vec("w_bot_hi",   100, 384, 0, 0, 1'b0, 1'b0, 1'b0);
        vec("w_left",      99, 200, 0, 0, 1'b0, 1'b0, 1'b0);
        vec("w_right",    540, 200, 0, 0, 1'b0, 1'b0, 1'b0);
        // pix_x=539: sum=439, idx=10 (S=37,d=4), phase=39 -> unlit
        vec("w_x539",     539, 200, 0, 0, 1'b0, 1'b0, 1'b0);
        // pix_x=500: sum=400, idx=10 d=4, phase 0, top band 184..243
        vec("w_idx10",    500, 184, 0, 0, 1'b0, 1'b0, 1'b1);
        vec("w_idx10b",   500, 183, 0, 0, 1'b0, 1'b0, 1'b0);

        // Scroll 40: idx1 d=22, top band 202..261, bottom 318..377
        vec("s_top",      100, 230, 0, 40, 1'b0, 1'b0, 1'b1);
        vec("s_above",    100, 201, 0, 40, 1'b0, 1'b0, 1'b0);
        vec("s_bot_hi",   100, 378, 0, 40, 1'b0, 1'b0, 1'b0);
        vec("s_bot_lo",   100, 318, 0, 40, 1'b0, 1'b0, 1'b1);
        // Scroll 600: sum=600, idx=15 (S=79,d=9), phase 0 -> top band 189..248
        vec("s_wrap",     100, 189, 0, 600, 1'b0, 1'b0, 1'b1);
        vec("s_wrap_b",   100, 188, 0, 600, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation: player hit lights two outputs.
        vec("pre_rst", 45, 210, 1, 0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.player", {31'd0, draw_player},     32'd0);
        check("arst.u",      {31'd0, draw_u},          32'd0);
        check("arst.wave",   {31'd0, draw_double_sin}, 32'd0);
        check("arst.on",     {31'd0, pixel_on},        32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Straight after release, the first edge reflects the current sample only.
        vec("post_rst_u",  304, 110, 0, 0, 1'b0, 1'b1, 1'b0);
        vec("post_rst_w",  100, 200, 0, 0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against an unterminated run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000 ns");
        $fatal(1);
    end

endmodule
